// File: rtl/alu_pkg.sv
// alu_pkg: ALU-facing types shared with the register file.
// Provides alu_status_t, the condition-flag group the ALU writes back.
package alu_pkg;

    typedef struct packed {
        logic n;    // negative
        logic z;    // zero
        logic c;    // carry
        logic v;    // overflow
    } alu_status_t;

endpackage

// File: rtl/reg_pkg.sv
// reg_pkg: architectural register naming and status word layout.
// Provides reg_e (R0-R12, FP, SP, PC), mode_e, status_t, the register
// count and the status reset value.
package reg_pkg;

    import alu_pkg::*;

    localparam int NUM_REGS = 16;

    typedef enum logic [3:0] {
        R0, R1, R2, R3, R4, R5, R6, R7,
        R8, R9, R10, R11, R12, FP, SP, PC
    } reg_e;

    typedef enum logic {
        USER       = 1'b0,
        SUPERVISOR = 1'b1
    } mode_e;

    typedef struct packed {
        alu_status_t alu_status;
        logic        imask;
        mode_e       mode;
    } status_t;

    localparam status_t STATUS_RESET = '{
        alu_status: alu_status_t'(4'b0000),
        imask:      1'b1,
        mode:       SUPERVISOR
    };

endpackage

// File: rtl/reg_file_status.sv
// status_reg: status word, interrupt-saved status and the RUN/INT flag.
// Applies flag/status writes with privilege checks, performs the status
// half of interrupt entry and return, and produces the irq_ack and
// priv_fault pulses.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   i_status_wr, i_status_in         full status write request
//   i_alu_status_wr, i_alu_status_in ALU flag update
//   i_rti                            return-from-interrupt request
//   i_int_entry                      interrupt entry this cycle (from top)
//   o_status                         current status
//   o_rti_take                       rti is legal and is taken this cycle
//   o_irq_ack, o_priv_fault          registered one-cycle pulses
module status_reg
    import alu_pkg::*;
    import reg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_status_wr,
    input  status_t     i_status_in,
    input  logic        i_alu_status_wr,
    input  alu_status_t i_alu_status_in,
    input  logic        i_rti,
    input  logic        i_int_entry,
    output status_t     o_status,
    output logic        o_rti_take,
    output logic        o_irq_ack,
    output logic        o_priv_fault
);

    status_t r_status;
    status_t r_saved_status;
    logic    r_in_int;
    logic    r_irq_ack;
    logic    r_priv_fault;

    logic    w_rti_take;
    logic    w_mode_violation;
    logic    w_fault;
    status_t w_status_upd;
    status_t w_status_entry;

    always_comb begin
        // rti is only honoured from supervisor code inside a handler
        w_rti_take = i_rti && r_in_int && (r_status.mode == SUPERVISOR);

        w_mode_violation = i_status_wr && (r_status.mode == USER) &&
                           ((i_status_in.mode  != r_status.mode) ||
                            (i_status_in.imask != r_status.imask));

        w_fault = (i_rti && !w_rti_take) || w_mode_violation;

        // Flag update first; a full status write overrides it on the flags.
        w_status_upd = r_status;
        if (i_alu_status_wr) begin
            w_status_upd.alu_status = i_alu_status_in;
        end
        if (i_status_wr) begin
            if (r_status.mode == SUPERVISOR) begin
                w_status_upd = i_status_in;
            end else begin
                w_status_upd.alu_status = i_status_in.alu_status;
            end
        end

        // Entry saves the already-updated word, then forces the handler context.
        w_status_entry       = w_status_upd;
        w_status_entry.mode  = SUPERVISOR;
        w_status_entry.imask = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_status       <= STATUS_RESET;
            r_saved_status <= '0;
            r_in_int       <= 1'b0;
            r_irq_ack      <= 1'b0;
            r_priv_fault   <= 1'b0;
        end else begin
            r_irq_ack    <= i_int_entry;
            r_priv_fault <= w_fault;
            if (i_int_entry) begin
                r_saved_status <= w_status_upd;
                r_status       <= w_status_entry;
                r_in_int       <= 1'b1;
            end else if (w_rti_take) begin
                r_status <= r_saved_status;
                r_in_int <= 1'b0;
            end else begin
                r_status <= w_status_upd;
            end
        end
    end

    assign o_status     = r_status;
    assign o_rti_take   = w_rti_take;
    assign o_irq_ack    = r_irq_ack;
    assign o_priv_fault = r_priv_fault;

endmodule

// File: rtl/reg_file.sv
// reg_file: architectural register file (R0-R12, FP, SP, PC) with PC
// sequencing, interrupt entry/return of the PC, and the status register.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   rd_sel_a/b, rd_data_a/b      combinational read ports (no bypass)
//   wr_en, wr_sel, wr_data       writeback port
//   pc_inc, pc                   instruction-boundary strobe, current PC
//   alu_status_wr/in             ALU flag update
//   status_wr/in, status         full status write, current status
//   irq, irq_ack                 level interrupt request, entry pulse
//   rti, priv_fault              return from interrupt, privilege fault pulse
module reg_file
    import alu_pkg::*;
    import reg_pkg::*;
#(
    parameter int                   WORD_SIZE  = 32,
    parameter logic [WORD_SIZE-1:0] RESET_PC   = '0,
    parameter logic [WORD_SIZE-1:0] INT_VECTOR = WORD_SIZE'(16)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  reg_e                 rd_sel_a,
    input  reg_e                 rd_sel_b,
    output logic [WORD_SIZE-1:0] rd_data_a,
    output logic [WORD_SIZE-1:0] rd_data_b,
    input  logic                 wr_en,
    input  reg_e                 wr_sel,
    input  logic [WORD_SIZE-1:0] wr_data,
    input  logic                 pc_inc,
    output logic [WORD_SIZE-1:0] pc,
    input  logic                 alu_status_wr,
    input  alu_status_t          alu_status_in,
    input  logic                 status_wr,
    input  status_t              status_in,
    output status_t              status,
    input  logic                 irq,
    output logic                 irq_ack,
    input  logic                 rti,
    output logic                 priv_fault
);

    logic [WORD_SIZE-1:0] r_regs [NUM_REGS];
    logic [WORD_SIZE-1:0] r_saved_pc;

    logic                 w_wr_pc;
    logic                 w_int_entry;
    logic                 w_rti_take;
    logic [WORD_SIZE-1:0] w_pc;
    logic [WORD_SIZE-1:0] w_pc_next_seq;
    status_t              w_status;

    assign w_pc          = r_regs[PC];
    assign w_pc_next_seq = w_pc + WORD_SIZE'(1);
    assign w_wr_pc       = wr_en && (wr_sel == PC);

    // Entry only at an instruction boundary, judged on the pre-cycle imask;
    // an explicit PC write or an rti in the same cycle suppresses it.
    assign w_int_entry = pc_inc && irq && !w_status.imask && !w_wr_pc && !rti;

    status_reg u_status_reg (
        .clk             (clk),
        .rst             (rst),
        .i_status_wr     (status_wr),
        .i_status_in     (status_in),
        .i_alu_status_wr (alu_status_wr),
        .i_alu_status_in (alu_status_in),
        .i_rti           (rti),
        .i_int_entry     (w_int_entry),
        .o_status        (w_status),
        .o_rti_take      (w_rti_take),
        .o_irq_ack       (irq_ack),
        .o_priv_fault    (priv_fault)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_regs[PC] <= RESET_PC;
            r_saved_pc <= '0;
        end else begin
            // General registers commit regardless of interrupt entry.
            if (wr_en && !w_wr_pc) begin
                r_regs[wr_sel] <= wr_data;
            end

            if (w_int_entry) begin
                r_saved_pc <= w_pc_next_seq;
                r_regs[PC] <= INT_VECTOR;
            end else if (w_rti_take) begin
                r_regs[PC] <= r_saved_pc;
            end else if (w_wr_pc) begin
                r_regs[PC] <= wr_data;
            end else if (pc_inc) begin
                r_regs[PC] <= w_pc_next_seq;   // wraps naturally at all-ones
            end
        end
    end

    assign rd_data_a = r_regs[rd_sel_a];
    assign rd_data_b = r_regs[rd_sel_b];
    assign pc        = w_pc;
    assign status    = w_status;

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;
    import alu_pkg::*;
    import reg_pkg::*;

    localparam logic [31:0] RST_PC  = 32'h0;
    localparam logic [31:0] INT_VEC = 32'h10;

    logic        clk = 1'b0;
    logic        rst;
    reg_e        rd_sel_a, rd_sel_b;
    logic [31:0] rd_data_a, rd_data_b;
    logic        wr_en;
    reg_e        wr_sel;
    logic [31:0] wr_data;
    logic        pc_inc;
    logic [31:0] pc;
    logic        alu_status_wr;
    alu_status_t alu_status_in;
    logic        status_wr;
    status_t     status_in;
    status_t     status;
    logic        irq, irq_ack, rti, priv_fault;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    reg_file #(.WORD_SIZE(32), .RESET_PC(RST_PC), .INT_VECTOR(INT_VEC)) dut (
        .clk(clk), .rst(rst),
        .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .pc_inc(pc_inc), .pc(pc),
        .alu_status_wr(alu_status_wr), .alu_status_in(alu_status_in),
        .status_wr(status_wr), .status_in(status_in), .status(status),
        .irq(irq), .irq_ack(irq_ack), .rti(rti), .priv_fault(priv_fault)
    );

    // Reference model: architectural state updated from the written rules.
    logic [31:0] m_regs [16];
    status_t     m_st, m_saved_st;
    logic [31:0] m_saved_pc;
    logic        m_in_int, m_ack, m_fault;

    function automatic void model_step();
        logic    entry, rti_ok, wr_pc;
        status_t nst;
        if (rst) begin
            for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
            m_regs[PC] = RST_PC;
            m_st = STATUS_RESET;
            m_saved_st = '0;
            m_saved_pc = 32'h0;
            m_in_int = 1'b0;
            m_ack = 1'b0;
            m_fault = 1'b0;
            return;
        end
        wr_pc  = wr_en && (wr_sel == PC);
        entry  = pc_inc && irq && !m_st.imask && !wr_pc && !rti;
        rti_ok = rti && m_in_int && (m_st.mode == SUPERVISOR);
        m_fault = rti && !rti_ok;
        m_ack   = entry;
        if (wr_en && !wr_pc) m_regs[wr_sel] = wr_data;
        nst = m_st;
        if (rti_ok) begin
            nst = m_saved_st;
        end else begin
            if (alu_status_wr) nst.alu_status = alu_status_in;
            if (status_wr) begin
                if (m_st.mode == SUPERVISOR) nst = status_in;
                else begin
                    nst.alu_status = status_in.alu_status;
                    if (status_in.mode != m_st.mode || status_in.imask != m_st.imask)
                        m_fault = 1'b1;
                end
            end
        end
        if (entry) begin
            m_saved_st = nst;
            nst.mode = SUPERVISOR;
            nst.imask = 1'b1;
            m_in_int = 1'b1;
            m_saved_pc = 32'(m_regs[PC] + 32'd1);
            m_regs[PC] = INT_VEC;
        end else if (rti_ok) begin
            m_in_int = 1'b0;
            m_regs[PC] = m_saved_pc;
        end else if (wr_pc) begin
            m_regs[PC] = wr_data;
        end else if (pc_inc) begin
            m_regs[PC] = 32'(m_regs[PC] + 32'd1);
        end
        m_st = nst;
    endfunction

    task automatic idle();
        rst = 1'b0; wr_en = 1'b0; wr_sel = R0; wr_data = 32'h0;
        pc_inc = 1'b0; alu_status_wr = 1'b0; alu_status_in = '0;
        status_wr = 1'b0; status_in = '0; irq = 1'b0; rti = 1'b0;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle(); rst = 1'b1; cycle(); idle();
        for (int i = 0; i < NUM_REGS; i++) begin
            logic [31:0] exp_a;
            rd_sel_a = reg_e'(i);
            rd_sel_b = reg_e'(i);
            #1;
            exp_a = (reg_e'(i) == PC) ? RST_PC : 32'h0;
            n_cmp++;
            if (rd_data_a !== exp_a) begin
                n_fail++;
                $display("FAIL reset_reg%0d: got %h expected %h", i, rd_data_a, exp_a);
            end
        end
        n_cmp++;
        if (status.mode !== SUPERVISOR || status.imask !== 1'b1 || status.alu_status !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_status: got %h expected mode=1 imask=1 flags=0", status);
        end
        n_cmp++;
        if (irq_ack !== 1'b0 || priv_fault !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pulses: irq_ack=%b priv_fault=%b expected 0 0", irq_ack, priv_fault);
        end
    endtask

    task automatic test_write_read();
        idle(); wr_en = 1'b1; wr_sel = R3; wr_data = 32'hDEADBEEF; rd_sel_a = R3;
        #1;
        n_cmp++;
        if (rd_data_a !== 32'h0) begin
            n_fail++;
            $display("FAIL write_no_bypass: got %h expected 00000000", rd_data_a);
        end
        cycle(); idle();
        n_cmp++;
        if (rd_data_a !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL write_visible: got %h expected deadbeef", rd_data_a);
        end
    endtask

    task automatic test_pc_wrap();
        idle(); wr_en = 1'b1; wr_sel = PC; wr_data = 32'hFFFFFFFF; cycle();
        idle(); pc_inc = 1'b1; cycle(); idle();
        n_cmp++;
        if (pc !== 32'h0) begin
            n_fail++;
            $display("FAIL pc_wrap: got %h expected 00000000", pc);
        end
        wr_en = 1'b1; wr_sel = PC; wr_data = 32'h40; pc_inc = 1'b1; cycle(); idle();
        n_cmp++;
        if (pc !== 32'h40) begin
            n_fail++;
            $display("FAIL pc_write_over_inc: got %h expected 00000040", pc);
        end
    endtask

    task automatic test_interrupt();
        status_t prior;
        prior = '{alu_status: alu_status_t'(4'b1010), imask: 1'b0, mode: SUPERVISOR};
        idle(); status_wr = 1'b1; status_in = prior; cycle();
        idle(); wr_en = 1'b1; wr_sel = PC; wr_data = 32'h20; cycle();
        idle(); irq = 1'b1; pc_inc = 1'b1; cycle(); idle();
        n_cmp++;
        if (pc !== 32'h10 || irq_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_entry: pc=%h irq_ack=%b expected 00000010 1", pc, irq_ack);
        end
        n_cmp++;
        if (status.mode !== SUPERVISOR || status.imask !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_entry_status: got %h expected mode=1 imask=1", status);
        end
        cycle();
        n_cmp++;
        if (irq_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_ack_width: got %b expected 0", irq_ack);
        end
        rti = 1'b1; cycle(); idle();
        n_cmp++;
        if (pc !== 32'h21 || status !== prior) begin
            n_fail++;
            $display("FAIL rti_restore: pc=%h status=%h expected 00000021 %h", pc, status, prior);
        end
    endtask

    task automatic test_user_status();
        idle(); status_wr = 1'b1; status_in = '{alu_status: alu_status_t'(4'b0), imask: 1'b0, mode: USER};
        cycle(); idle();
        status_wr = 1'b1;
        status_in = '{alu_status: alu_status_t'(4'b0111), imask: 1'b1, mode: SUPERVISOR};
        cycle(); idle();
        n_cmp++;
        if (status.alu_status !== 4'b0111 || status.mode !== USER || status.imask !== 1'b0) begin
            n_fail++;
            $display("FAIL user_status_wr: got %h expected flags=7 imask=0 mode=0", status);
        end
        n_cmp++;
        if (priv_fault !== 1'b1) begin
            n_fail++;
            $display("FAIL user_priv_fault: got %b expected 1", priv_fault);
        end
        cycle();
        n_cmp++;
        if (priv_fault !== 1'b0) begin
            n_fail++;
            $display("FAIL priv_fault_width: got %b expected 0", priv_fault);
        end
    endtask

    task automatic test_rti_in_run();
        idle(); rst = 1'b1; cycle(); idle();
        wr_en = 1'b1; wr_sel = PC; wr_data = 32'h5; cycle(); idle();
        rti = 1'b1; cycle(); idle();
        n_cmp++;
        if (pc !== 32'h5 || status !== STATUS_RESET || priv_fault !== 1'b1) begin
            n_fail++;
            $display("FAIL rti_in_run: pc=%h status=%h fault=%b expected 00000005 %h 1",
                     pc, status, priv_fault, STATUS_RESET);
        end
    endtask

    task automatic test_reset_in_int();
        idle(); status_wr = 1'b1; status_in = '{alu_status: alu_status_t'(4'b0), imask: 1'b0, mode: SUPERVISOR};
        cycle(); idle();
        irq = 1'b1; pc_inc = 1'b1; cycle(); idle();
        n_cmp++;
        if (irq_ack !== 1'b1 || pc !== INT_VEC) begin
            n_fail++;
            $display("FAIL int_before_reset: irq_ack=%b pc=%h expected 1 %h", irq_ack, pc, INT_VEC);
        end
        rst = 1'b1; cycle(); idle();
        n_cmp++;
        if (pc !== RST_PC || status !== STATUS_RESET) begin
            n_fail++;
            $display("FAIL reset_in_int: pc=%h status=%h expected %h %h", pc, status, RST_PC, STATUS_RESET);
        end
        rti = 1'b1; cycle(); idle();
        n_cmp++;
        if (priv_fault !== 1'b1 || pc !== RST_PC) begin
            n_fail++;
            $display("FAIL run_after_reset: fault=%b pc=%h expected 1 %h", priv_fault, pc, RST_PC);
        end
    endtask

    task automatic test_random();
        idle(); rst = 1'b1; cycle();
        for (int n = 0; n < 3000; n++) begin
            rst           = ($urandom_range(99) == 0);
            wr_en         = ($urandom_range(2) == 0);
            wr_sel        = reg_e'(4'($urandom));
            wr_data       = (wr_sel == PC && $urandom_range(3) == 0) ? 32'hFFFFFFFF : $urandom;
            pc_inc        = $urandom_range(1) == 1;
            alu_status_wr = ($urandom_range(3) == 0);
            alu_status_in = alu_status_t'(4'($urandom));
            status_wr     = ($urandom_range(7) == 0);
            status_in     = status_t'(6'($urandom));
            irq           = $urandom_range(1) == 1;
            rti           = ($urandom_range(7) == 0);
            rd_sel_a      = reg_e'(4'($urandom));
            rd_sel_b      = reg_e'(4'($urandom));
            cycle();
            n_cmp++;
            if (pc !== m_regs[PC] || status !== m_st) begin
                n_fail++;
                $display("FAIL rand_state[%0d]: pc=%h status=%h expected %h %h", n, pc, status, m_regs[PC], m_st);
            end
            n_cmp++;
            if (irq_ack !== m_ack || priv_fault !== m_fault) begin
                n_fail++;
                $display("FAIL rand_pulses[%0d]: ack=%b fault=%b expected %b %b", n, irq_ack, priv_fault, m_ack, m_fault);
            end
            n_cmp++;
            if (rd_data_a !== m_regs[rd_sel_a] || rd_data_b !== m_regs[rd_sel_b]) begin
                n_fail++;
                $display("FAIL rand_read[%0d]: a=%h b=%h expected %h %h", n, rd_data_a, rd_data_b,
                         m_regs[rd_sel_a], m_regs[rd_sel_b]);
            end
        end
        idle();
    endtask

    initial begin
        idle();
        rd_sel_a = R0;
        rd_sel_b = R0;
        #1;
        test_reset();
        test_write_read();
        test_pc_wrap();
        test_interrupt();
        test_user_status();
        test_rti_in_run();
        test_reset_in_int();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file.md
# reg_file

Architectural register file and status register for the CPU core: sixteen `WORD_SIZE` registers indexed by `reg_pkg::reg_e` (R0–R12, FP, SP, PC), the packed `status_t` word, and a single-level interrupt save/restore. Sits between decode (read selects), the ALU (flag updates) and writeback (register writes). Owns PC sequencing and privilege enforcement on the status word.

## Interface
- `WORD_SIZE`, 32, register width
- `RESET_PC`, 0, PC value after reset
- `INT_VECTOR`, 'h10, PC loaded on interrupt entry
---
- `clk` in 1: clock, all state updates on rising edge
- `rst` in 1: reset, synchronous, active-high
- `rd_sel_a`, `rd_sel_b` in `reg_e`: read selects
- `rd_data_a`, `rd_data_b` out `WORD_SIZE`: combinational read of stored value (no write bypass)
- `wr_en` in 1, `wr_sel` in `reg_e`, `wr_data` in `WORD_SIZE`: writeback port
- `pc_inc` in 1: instruction-boundary strobe; PC += 1 (word addressed)
- `pc` out `WORD_SIZE`: current PC (same as reading PC)
- `alu_status_wr` in 1, `alu_status_in` in `alu_status_t`: flag update
- `status_wr` in 1, `status_in` in `status_t`: full status write
- `status` out `status_t`: current status
- `irq` in 1: level interrupt request
- `irq_ack` out 1: one-cycle pulse on interrupt entry
- `rti` in 1: return from interrupt
- `priv_fault` out 1: one-cycle pulse on illegal privileged write

## Operation
- Reset: all GPRs/FP/SP 0, PC = `RESET_PC`, status = `{alu_status 0, imask 1, SUPERVISOR}`, saved_pc/saved_status 0, `in_int` 0, `irq_ack`/`priv_fault` 0.
- States: `RUN` (`in_int`=0) and `INT` (`in_int`=1).
- Interrupt entry condition: `pc_inc && irq && !status.imask && !(wr_en && wr_sel==PC) && !rti`. On entry: saved_pc ← PC+1, saved_status ← status, PC ← `INT_VECTOR`, mode ← SUPERVISOR, imask ← 1, `in_int` ← 1, `irq_ack` = 1 next cycle. Non-PC `wr_en` in the same cycle still commits.
- Entry is evaluated against the pre-cycle status. If `status_wr` or `alu_status_wr` occurs in the same cycle, it applies first, then entry saves the updated value and forces mode/imask.
- `rti` in `INT`: PC ← saved_pc, status ← saved_status, `in_int` ← 0. Overrides `pc_inc`, `wr_en` to PC, and status writes. `rti` in `RUN` or in USER mode: ignored, `priv_fault` pulses.
- PC priority, highest first: rst > interrupt entry > rti > `wr_en` to PC > `pc_inc`. PC wraps from all-ones to 0.
- `status_wr` in SUPERVISOR: full write.
- `status_wr` in USER: only `alu_status` is written. If `status_in.mode` or `status_in.imask` differs from current, `priv_fault` pulses.
- `alu_status_wr` and `status_wr` together: `status_wr` wins on `alu_status`.
- Nested interrupts: if supervisor clears imask while in `INT`, a new entry overwrites saved state. This is software's responsibility; no extra handling.
- `irq` is level-sensitive with no internal latch. Deassertion before a boundary drops the request.

## Timing
- Reads: combinational, zero latency. A write is visible on reads the cycle after `wr_en`.
- `pc`/`status` update one cycle after the controlling strobe.
- `irq_ack` and `priv_fault` are registered and high exactly one cycle, the cycle after the event.
- Reset mid-interrupt: returns to `RUN` and clears saved state.

## Structure
- `reg_pkg` gains `STATUS_RESET` (`status_t` constant) and `localparam` for register count (16). Index by `reg_e`, no raw literals.
- `alu_status_t` is taken unmodified from `alu_pkg`.
- Sub-module `status_reg` holds status, saved_status, `in_int` and privilege checks. The top module holds the register array and PC sequencing.

## Test plan
- Reset, then read all 16 regs → 0 except PC = `RESET_PC`; status = SUPERVISOR, imask 1.
- Write R3 = 'hDEADBEEF with `rd_sel_a`=R3 in the same cycle → old 0 read; 'hDEADBEEF next cycle.
- PC = 'hFFFFFFFF, `pc_inc` → PC 0. Simultaneous `wr_en` PC='h40 and `pc_inc` → PC 'h40.
- imask 0, PC 'h20, `irq` + `pc_inc` → PC 'h10, saved_pc 'h21, `irq_ack` 1 cycle, mode SUPERVISOR, imask 1. Then `rti` → PC 'h21, prior status restored.
- USER mode, `status_wr` with mode=SUPERVISOR and new flags → flags updated, mode stays USER, `priv_fault` pulses once.
- `rti` while `in_int`=0 → no PC/status change, `priv_fault` pulse. `rst` during `INT` → `RUN`, PC = `RESET_PC`.
